// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the 16-bit LFSR noise stream (x^16+x^14+x^13+x^11+1).
// Seeds from received data, flywheels once locked, and counts word/bit errors.
module lfsr_sequence_checker #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 8,
    parameter int unsigned ERR_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      data_in,
    input  logic             data_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] word_err_cnt,
    output logic [ERR_W-1:0] bit_err_cnt
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned UW = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned SW = ERR_W + 5;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       pred_q, pred_d;
    logic [MW-1:0]     match_q, match_d;
    logic [UW-1:0]     miss_q, miss_d;
    logic              err_d;
    logic [ERR_W-1:0]  word_d, bit_d;
    logic [4:0]        pop;
    logic [15:0]       diff;
    logic [SW-1:0]     bit_sum;
    logic              is_match;

    function automatic logic [15:0] step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    assign is_match = (data_in == pred_q);
    assign diff     = data_in ^ pred_q;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            pop = pop + 5'(diff[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HUNT;
            pred_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_pulse <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        if (data_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (data_in != '0) begin
                        pred_d  = step(data_in);
                        match_d = '0;
                        state_d = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (is_match) begin
                        pred_d  = step(data_in);
                        match_d = match_q + MW'(1);
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (data_in != '0) begin
                        pred_d  = step(data_in);
                        match_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances from itself, never from received data.
                    pred_d = step(pred_q);
                    if (is_match) begin
                        miss_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_q + UW'(1);
                        if (miss_q == UW'(UNLOCK_COUNT - 1)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign bit_sum = SW'(bit_err_cnt) + SW'(pop);

    always_comb begin
        word_d = word_err_cnt;
        bit_d  = bit_err_cnt;
        if (clear_cnt) begin
            word_d = '0;
            bit_d  = '0;
        end else if (err_d) begin
            if (word_err_cnt != '1) begin
                word_d = word_err_cnt + ERR_W'(1);
            end
            bit_d = (bit_sum > SW'({ERR_W{1'b1}})) ? '1 : bit_sum[ERR_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_err_cnt <= '0;
            bit_err_cnt  <= '0;
        end else begin
            word_err_cnt <= word_d;
            bit_err_cnt  <= bit_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Directed bench for lfsr_sequence_checker: lock/flywheel/unlock, valid gaps,
// saturating counters (narrow instance) and asynchronous reset.
module tb_lfsr_sequence_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        data_valid;
    logic        clear_cnt;

    logic        locked, err_pulse;
    logic [15:0] word_err_cnt, bit_err_cnt;
    logic        s_locked, s_err_pulse;
    logic [3:0]  s_word_err_cnt, s_bit_err_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [15:0] cur, w;

    always #5 clk = ~clk;

    lfsr_sequence_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(8), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
        .word_err_cnt(word_err_cnt), .bit_err_cnt(bit_err_cnt)
    );

    lfsr_sequence_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(32), .ERR_W(4)) dut_sat (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear_cnt(clear_cnt), .locked(s_locked), .err_pulse(s_err_pulse),
        .word_err_cnt(s_word_err_cnt), .bit_err_cnt(s_bit_err_cnt)
    );

    function automatic logic [15:0] step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One valid word; returns #1 after the sampling edge.
    task automatic feed(input logic [15:0] word);
        data_in    = word;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic idle_cycle(input logic [15:0] junk);
        data_in    = junk;
        data_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Seed plus LOCK_COUNT successors; checks lock is absent after 4 and present after 5.
    task automatic lock_from(input logic [15:0] seed, input string tag);
        cur = seed;
        feed(cur);
        for (int i = 0; i < 3; i++) begin
            cur = step(cur);
            feed(cur);
        end
        check({tag, "_not_yet"}, 32'(locked), 32'd0);
        cur = step(cur);
        feed(cur);
        check({tag, "_locked"}, 32'(locked), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; data_in = '0; data_valid = 1'b0; clear_cnt = 1'b0;
        #12;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err",    32'(err_pulse), 32'd0);
        check("rst_words",  32'(word_err_cnt), 32'd0);
        check("rst_bits",   32'(bit_err_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: lock on ACE1 stream
        check("step_ex", 32'(step(16'hACE1)), 32'h59C3);
        lock_from(16'hACE1, "t1");
        check("t1_words", 32'(word_err_cnt), 32'd0);
        check("t1_bits",  32'(bit_err_cnt), 32'd0);

        // 2: single 2-bit error, then flywheel continues
        w = step(cur);
        feed(w ^ 16'h0005);
        cur = w;
        check("t2_pulse", 32'(err_pulse), 32'd1);
        check("t2_words", 32'(word_err_cnt), 32'd1);
        check("t2_bits",  32'(bit_err_cnt), 32'd2);
        cur = step(cur);
        feed(cur);
        check("t2_pulse_clr", 32'(err_pulse), 32'd0);
        check("t2_locked",    32'(locked), 32'd1);
        check("t2_words_hold", 32'(word_err_cnt), 32'd1);

        // 3: clear counters, then unrelated stream forces re-hunt and relock
        clear_cnt = 1'b1;
        idle_cycle(16'h0000);
        clear_cnt = 1'b0;
        check("t3_clr_words", 32'(word_err_cnt), 32'd0);
        check("t3_clr_bits",  32'(bit_err_cnt), 32'd0);
        check("t3_clr_locked", 32'(locked), 32'd1);
        cur = 16'h1234;
        for (int i = 0; i < 7; i++) begin
            feed(cur);
            cur = step(cur);
        end
        check("t3_locked_7", 32'(locked), 32'd1);
        feed(cur);
        check("t3_locked_8", 32'(locked), 32'd0);
        check("t3_pulse_8",  32'(err_pulse), 32'd1);
        check("t3_words",    32'(word_err_cnt), 32'd8);
        lock_from(step(cur), "t3_relock");
        check("t3_words_hold", 32'(word_err_cnt), 32'd8);

        // 4: random valid gaps on a correct stream
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                idle_cycle(~step(cur));
                check("t4_gap_pulse", 32'(err_pulse), 32'd0);
            end
            cur = step(cur);
            feed(cur);
        end
        check("t4_locked", 32'(locked), 32'd1);
        check("t4_words",  32'(word_err_cnt), 32'd8);
        // zeros in HUNT are ignored
        reset = 1'b1; #2; reset = 1'b0;
        feed(16'h0000);
        feed(16'h0000);
        check("t4_zero_hunt", 32'(locked), 32'd0);
        lock_from(16'hBEEF, "t4_after_zero");

        // 5: saturation on the 4-bit instance
        reset = 1'b1; #2; reset = 1'b0;
        lock_from(16'hACE1, "t5");
        check("t5_sat_locked", 32'(s_locked), 32'd1);
        w = step(cur);
        feed(~w);
        cur = w;
        check("t5_sat_words_1", 32'(s_word_err_cnt), 32'd1);
        check("t5_sat_bits_1",  32'(s_bit_err_cnt), 32'd15);
        for (int i = 0; i < 19; i++) begin
            w = step(cur);
            feed(~w);
            cur = w;
        end
        check("t5_sat_words", 32'(s_word_err_cnt), 32'd15);
        check("t5_sat_bits",  32'(s_bit_err_cnt), 32'd15);
        check("t5_sat_locked2", 32'(s_locked), 32'd1);
        check("t5_dut_unlocked", 32'(locked), 32'd0);
        w = step(cur);
        clear_cnt = 1'b1;
        feed(~w);
        clear_cnt = 1'b0;
        cur = w;
        check("t5_clr_pulse", 32'(s_err_pulse), 32'd1);
        check("t5_clr_words", 32'(s_word_err_cnt), 32'd0);
        check("t5_clr_bits",  32'(s_bit_err_cnt), 32'd0);
        check("t5_clr_locked", 32'(s_locked), 32'd1);

        // 6: async reset while locked with an error pulse in flight
        for (int i = 0; i < 5; i++) begin
            cur = step(cur);
            feed(cur);
        end
        check("t6_locked", 32'(locked), 32'd1);
        w = step(cur);
        feed(~w);
        cur = w;
        check("t6_pulse", 32'(err_pulse), 32'd1);
        check("t6_words", 32'(word_err_cnt), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_locked", 32'(locked), 32'd0);
        check("t6_rst_pulse",  32'(err_pulse), 32'd0);
        check("t6_rst_words",  32'(word_err_cnt), 32'd0);
        check("t6_rst_bits",   32'(bit_err_cnt), 32'd0);
        check("t6_rst_sat_locked", 32'(s_locked), 32'd0);
        #2;
        reset = 1'b0;
        lock_from(16'hACE1, "t6_relock");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
